// File: rtl/tdc_readout_sched_pkg.sv
// Shared constants, scheduler state encoding and index helper for the TDC readout scheduler.
package tdc_readout_sched_pkg;

    localparam int unsigned DIG_OUT     = 12;
    localparam int unsigned TMO_CYC_DEF = 4096;
    localparam int unsigned TMO_W_DEF   = 13;

    typedef enum logic {
        SCHED_IDLE    = 1'b0,
        SCHED_PRESENT = 1'b1
    } sched_state_e;

    // Modular channel index: (base + off) mod n, valid for base < n and off <= n.
    function automatic int unsigned wrap_add(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        int unsigned s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/tdc_readout_sched_if.sv
// Result stream from the readout scheduler: word, source channel, valid/ready handshake.
interface tdc_readout_sched_if #(
    parameter int unsigned W    = tdc_readout_sched_pkg::DIG_OUT,
    parameter int unsigned CH_W = 2
);
    logic [W-1:0]    oData;
    logic [CH_W-1:0] oCh;
    logic            oValid;
    logic            iReady;

    modport master (output oData, output oCh, output oValid, input iReady);
    modport slave  (input oData, input oCh, input oValid, output iReady);
endinterface

// File: rtl/tdc_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel strictly after ptr, wrapping.
module tdc_rr_arbiter
    import tdc_readout_sched_pkg::*;
#(
    parameter  int unsigned N_CH = 4,
    localparam int unsigned CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] grant_c,
    output logic            any_c
);

    int unsigned idx;

    // Walk from farthest to nearest offset so the nearest requester is written last.
    always_comb begin
        grant_c = '0;
        any_c   = 1'b0;
        idx     = 0;
        for (int unsigned k = N_CH; k > 0; k--) begin
            idx = wrap_add(32'(ptr), k, N_CH);
            if (req[CH_W'(idx)]) begin
                grant_c = CH_W'(idx);
                any_c   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdc_readout_sched.sv
// Readout scheduler: arms N_CH TDCs, holds one result per channel, drains them round-robin.
// Optional per-channel watchdog enabled by defining TDC_TIMEOUT_EN.
module tdc_readout_sched
    import tdc_readout_sched_pkg::*;
#(
    parameter  int unsigned N_CH    = 4,
    parameter  int unsigned W       = DIG_OUT,
    parameter  int unsigned TMO_CYC = TMO_CYC_DEF,
    parameter  int unsigned TMO_W   = TMO_W_DEF,
    localparam int unsigned CH_W    = $clog2(N_CH)
) (
    input  logic                clk0,
    input  logic                iRst,
    input  logic                iEnable,
    input  logic [N_CH-1:0]     iDone,
    input  logic [N_CH*W-1:0]   iTDC,
    input  logic [N_CH-1:0]     iBusy,
    output logic [N_CH-1:0]     oArm,
    output logic [N_CH-1:0]     oChRst,
    output logic [N_CH-1:0]     oOvf,
    input  logic                iClrOvf,
    output logic [N_CH-1:0]     oTmo,
    tdc_readout_sched_if.master rd
);

    sched_state_e    state, state_n;
    logic [N_CH-1:0] full, full_n, consume, drop, tmo_fire;
    logic [W-1:0]    slot [N_CH];
    logic [CH_W-1:0] ptr, grant_c;
    logic            any_c, load, accept;

    tdc_rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req     (full),
        .ptr     (ptr),
        .grant_c (grant_c),
        .any_c   (any_c)
    );

    always_ff @(posedge clk0 or posedge iRst) begin
        if (iRst) state <= SCHED_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        accept  = 1'b0;
        case (state)
            SCHED_IDLE: begin
                if (any_c) begin
                    load    = 1'b1;
                    state_n = SCHED_PRESENT;
                end
            end
            SCHED_PRESENT: begin
                if (rd.oValid && rd.iReady) begin
                    accept  = 1'b1;
                    state_n = SCHED_IDLE;
                end
            end
            default: state_n = SCHED_IDLE;
        endcase
    end

    // A refill landing on the cycle the slot is consumed is kept, not dropped.
    always_comb begin
        consume = '0;
        drop    = '0;
        full_n  = '0;
        for (int i = 0; i < N_CH; i++) begin
            consume[i] = accept && (rd.oCh == CH_W'(i));
            drop[i]    = iDone[i] && full[i] && !consume[i];
            full_n[i]  = (full[i] && !consume[i]) || iDone[i];
        end
    end

    always_ff @(posedge clk0 or posedge iRst) begin
        if (iRst) begin
            full      <= '0;
            oArm      <= '0;
            oOvf      <= '0;
            ptr       <= CH_W'(N_CH - 1);
            rd.oValid <= 1'b0;
            rd.oData  <= '0;
            rd.oCh    <= '0;
            for (int i = 0; i < N_CH; i++) slot[i] <= '0;
        end else begin
            full <= full_n;
            for (int i = 0; i < N_CH; i++) begin
                if (iDone[i] && !drop[i]) slot[i] <= iTDC[i*W +: W];
            end
            oArm <= {N_CH{iEnable}} & ~full_n & ~tmo_fire;
            oOvf <= (iClrOvf ? '0 : oOvf) | drop;
            if (load) begin
                rd.oData  <= slot[grant_c];
                rd.oCh    <= grant_c;
                rd.oValid <= 1'b1;
            end else if (accept) begin
                rd.oValid <= 1'b0;
                ptr       <= rd.oCh;
            end
        end
    end

`ifdef TDC_TIMEOUT_EN
    logic [TMO_W-1:0] wd_cnt [N_CH];

    // Watchdog only runs while the channel is armed and its hit-enabler reports a measurement.
    always_comb begin
        tmo_fire = '0;
        for (int i = 0; i < N_CH; i++) begin
            tmo_fire[i] = oArm[i] && iBusy[i] && !iDone[i] &&
                          (wd_cnt[i] == TMO_W'(TMO_CYC - 1));
        end
    end

    always_ff @(posedge clk0 or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < N_CH; i++) wd_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (iDone[i] || !iBusy[i] || tmo_fire[i]) wd_cnt[i] <= '0;
                else if (oArm[i])                         wd_cnt[i] <= wd_cnt[i] + TMO_W'(1);
            end
        end
    end
`else
    logic unused_cfg;

    assign tmo_fire   = '0;
    assign unused_cfg = ^{iBusy, 32'(TMO_CYC), 32'(TMO_W)};
`endif

    always_ff @(posedge clk0 or posedge iRst) begin
        if (iRst) begin
            oChRst <= '0;
            oTmo   <= '0;
        end else begin
            oChRst <= tmo_fire;
            oTmo   <= (iClrOvf ? '0 : oTmo) | tmo_fire;
        end
    end

endmodule

// File: tb/tb_tdc_readout_sched.sv
// Self-checking bench for tdc_readout_sched: directed scenarios plus randomized traffic vs a reference model.
module tb_tdc_readout_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 12;
    localparam int unsigned TMO = 16;
    localparam int unsigned TW = 5;
    localparam int unsigned CW = 2;

    logic           clk0 = 1'b0;
    logic           iRst;
    logic           iEnable;
    logic [N-1:0]   iDone;
    logic [N*W-1:0] iTDC;
    logic [N-1:0]   iBusy;
    logic [N-1:0]   oArm;
    logic [N-1:0]   oChRst;
    logic [N-1:0]   oOvf;
    logic           iClrOvf;
    logic [N-1:0]   oTmo;

    tdc_readout_sched_if #(.W(W), .CH_W(CW)) bus ();

    tdc_readout_sched #(.N_CH(N), .W(W), .TMO_CYC(TMO), .TMO_W(TW)) dut (
        .clk0    (clk0),
        .iRst    (iRst),
        .iEnable (iEnable),
        .iDone   (iDone),
        .iTDC    (iTDC),
        .iBusy   (iBusy),
        .oArm    (oArm),
        .oChRst  (oChRst),
        .oOvf    (oOvf),
        .iClrOvf (iClrOvf),
        .oTmo    (oTmo),
        .rd      (bus)
    );

    always #5 clk0 = ~clk0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one result buffer per channel, one word on offer, rotating priority.
    bit           m_full [N];
    logic [W-1:0] m_slot [N];
    logic [N-1:0] m_ovf, m_arm;
    bit           m_valid;
    logic [W-1:0] m_out;
    int           m_ch, m_ptr;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin m_full[i] = 0; m_slot[i] = '0; end
        m_ovf = '0; m_arm = '0; m_valid = 0; m_out = '0; m_ch = 0; m_ptr = N - 1;
    endtask

    task automatic model_step();
        bit acc, found;
        int pc;
        logic [W-1:0] pdata;
        logic [N-1:0] ev;
        acc = m_valid && bus.iReady;
        found = 0; pc = 0; pdata = '0; ev = '0;
        if (!m_valid) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!found && m_full[c]) begin found = 1; pc = c; pdata = m_slot[c]; end
            end
        end
        for (int i = 0; i < N; i++) begin
            bit cons;
            cons = acc && (m_ch == i);
            if (iDone[i]) begin
                if (m_full[i] && !cons) ev[i] = 1'b1;
                else begin m_full[i] = 1; m_slot[i] = iTDC[i*W +: W]; end
            end else if (cons) m_full[i] = 0;
            m_arm[i] = iEnable && !m_full[i];
        end
        m_ovf = (iClrOvf ? '0 : m_ovf) | ev;
        if (acc) begin
            m_valid = 0; m_ptr = m_ch;
        end else if (!m_valid && found) begin
            m_valid = 1; m_out = pdata; m_ch = pc;
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        if (!iRst) model_step();
        #1;
    endtask

    task automatic set_tdc(input int ch, input logic [W-1:0] v);
        iTDC[ch*W +: W] = v;
    endtask

    task automatic do_reset();
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        model_reset();
        iEnable = 1'b1; bus.iReady = 1'b1; iDone = '0; iClrOvf = 1'b0; iBusy = '0;
        tick();
    endtask

    task automatic test_reset();
        iRst = 1'b1; iEnable = 1'b1; iDone = '0; iTDC = '0; iBusy = '0; iClrOvf = 1'b0; bus.iReady = 1'b1;
        tick(); tick();
        n_cmp++; if (bus.oValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.oValid); end
        n_cmp++; if ({oArm, oChRst, oOvf, oTmo} !== '0) begin n_bad++; $display("FAIL reset_flags: got %h want 0", {oArm, oChRst, oOvf, oTmo}); end
        n_cmp++; if ({bus.oData, bus.oCh} !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {bus.oData, bus.oCh}); end
        iRst = 1'b0; model_reset();
        tick();
        n_cmp++; if (oArm !== 4'hF) begin n_bad++; $display("FAIL arm_after_reset: got %h want f", oArm); end
    endtask

    task automatic test_single();
        do_reset();
        set_tdc(2, 12'h1A5); iDone = 4'b0100;
        tick(); iDone = '0;
        n_cmp++; if (oArm[2] !== 1'b0 || bus.oValid !== 1'b0) begin n_bad++; $display("FAIL single_t1: arm2=%b valid=%b want 0 0", oArm[2], bus.oValid); end
        tick();
        n_cmp++; if (bus.oValid !== 1'b1 || bus.oData !== 12'h1A5 || bus.oCh !== 2'd2) begin n_bad++; $display("FAIL single_word: valid=%b data=%h ch=%0d want 1 1a5 2", bus.oValid, bus.oData, bus.oCh); end
        n_cmp++; if (oArm[2] !== 1'b0) begin n_bad++; $display("FAIL single_arm_t2: got %b want 0", oArm[2]); end
        tick();
        n_cmp++; if (bus.oValid !== 1'b0) begin n_bad++; $display("FAIL single_drop_valid: got %b want 0", bus.oValid); end
        tick();
        n_cmp++; if (oArm[2] !== 1'b1) begin n_bad++; $display("FAIL single_rearm: got %b want 1", oArm[2]); end
    endtask

    task automatic test_multi();
        int got_ch[$], got_at[$];
        logic [W-1:0] got_d[$];
        int exp_ch[3] = '{0, 1, 3};
        int exp_at[3] = '{2, 4, 6};
        logic [W-1:0] exp_d[3] = '{12'h111, 12'h222, 12'h333};
        do_reset();
        set_tdc(0, 12'h111); set_tdc(1, 12'h222); set_tdc(3, 12'h333); iDone = 4'b1011;
        tick(); iDone = '0;
        for (int t = 2; t <= 9; t++) begin
            tick();
            if (bus.oValid) begin got_ch.push_back(int'(bus.oCh)); got_at.push_back(t); got_d.push_back(bus.oData); end
        end
        n_cmp++; if (got_ch.size() != 3) begin n_bad++; $display("FAIL multi_count: got %0d want 3", got_ch.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (got_ch[i] != exp_ch[i] || got_at[i] != exp_at[i] || got_d[i] !== exp_d[i]) begin
                    n_bad++; $display("FAIL multi_word%0d: ch=%0d at=%0d data=%h want %0d %0d %h", i, got_ch[i], got_at[i], got_d[i], exp_ch[i], exp_at[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.iReady = 1'b0;
        set_tdc(1, 12'h0AB); iDone = 4'b0010;
        tick(); iDone = '0;
        tick();
        n_cmp++; if (bus.oValid !== 1'b1 || bus.oData !== 12'h0AB) begin n_bad++; $display("FAIL bp_first: valid=%b data=%h want 1 0ab", bus.oValid, bus.oData); end
        set_tdc(1, 12'h0CD); iDone = 4'b0010;
        tick(); iDone = '0;
        n_cmp++; if (oOvf !== 4'b0010) begin n_bad++; $display("FAIL bp_ovf: got %b want 0010", oOvf); end
        tick(); tick(); tick();
        n_cmp++; if (bus.oValid !== 1'b1 || bus.oData !== 12'h0AB || bus.oCh !== 2'd1) begin n_bad++; $display("FAIL bp_hold: valid=%b data=%h ch=%0d want 1 0ab 1", bus.oValid, bus.oData, bus.oCh); end
        iClrOvf = 1'b1; tick(); iClrOvf = 1'b0;
        n_cmp++; if (oOvf !== 4'b0000) begin n_bad++; $display("FAIL bp_clr: got %b want 0000", oOvf); end
        bus.iReady = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (bus.oValid !== 1'b0) begin n_bad++; $display("FAIL bp_no_dropped_word: got %b want 0", bus.oValid); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        set_tdc(0, 12'h055); iDone = 4'b0001;
        tick(); iDone = '0;
        tick();
        n_cmp++; if (bus.oValid !== 1'b1 || bus.oData !== 12'h055) begin n_bad++; $display("FAIL sc_first: valid=%b data=%h want 1 055", bus.oValid, bus.oData); end
        set_tdc(0, 12'h066); iDone = 4'b0001;
        tick(); iDone = '0;
        n_cmp++; if (bus.oValid !== 1'b0 || oOvf !== 4'b0000) begin n_bad++; $display("FAIL sc_accept: valid=%b ovf=%b want 0 0000", bus.oValid, oOvf); end
        tick();
        n_cmp++; if (bus.oValid !== 1'b1 || bus.oData !== 12'h066 || bus.oCh !== 2'd0) begin n_bad++; $display("FAIL sc_second: valid=%b data=%h ch=%0d want 1 066 0", bus.oValid, bus.oData, bus.oCh); end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
`ifdef TDC_TIMEOUT_EN
        iBusy = 4'b1000;
        for (int k = 1; k <= 15; k++) tick();
        n_cmp++; if (oChRst !== 4'b0000) begin n_bad++; $display("FAIL tmo_early: got %b want 0000", oChRst); end
        tick();
        n_cmp++; if (oChRst !== 4'b1000 || oArm[3] !== 1'b0) begin n_bad++; $display("FAIL tmo_pulse: chrst=%b arm3=%b want 1000 0", oChRst, oArm[3]); end
        tick();
        n_cmp++; if (oChRst !== 4'b0000 || oTmo !== 4'b1000 || oArm[3] !== 1'b1) begin n_bad++; $display("FAIL tmo_after: chrst=%b tmo=%b arm3=%b want 0000 1000 1", oChRst, oTmo, oArm[3]); end
        iClrOvf = 1'b1; tick(); iClrOvf = 1'b0;
        n_cmp++; if (oTmo !== 4'b0000) begin n_bad++; $display("FAIL tmo_clr: got %b want 0000", oTmo); end
`else
        iBusy = 4'b1111;
        for (int k = 1; k <= 20; k++) tick();
        n_cmp++; if (oChRst !== 4'b0000 || oTmo !== 4'b0000) begin n_bad++; $display("FAIL notmo_flags: chrst=%b tmo=%b want 0", oChRst, oTmo); end
        n_cmp++; if (oArm !== 4'hF) begin n_bad++; $display("FAIL notmo_arm: got %h want f", oArm); end
`endif
        iBusy = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.iReady = 1'b0;
        set_tdc(3, 12'h7E7); iDone = 4'b1000;
        tick(); iDone = '0;
        tick();
        n_cmp++; if (bus.oValid !== 1'b1) begin n_bad++; $display("FAIL rm_setup: got %b want 1", bus.oValid); end
        #2 iRst = 1'b1;
        #1;
        n_cmp++; if (bus.oValid !== 1'b0 || oArm !== 4'h0 || bus.oData !== '0) begin n_bad++; $display("FAIL rm_async: valid=%b arm=%h data=%h want 0 0 0", bus.oValid, oArm, bus.oData); end
        tick();
        iRst = 1'b0; model_reset(); bus.iReady = 1'b1;
        tick(); tick();
        n_cmp++; if (bus.oValid !== 1'b0 || oArm !== 4'hF) begin n_bad++; $display("FAIL rm_empty: valid=%b arm=%h want 0 f", bus.oValid, oArm); end
        set_tdc(1, 12'h3C3); iDone = 4'b0010;
        tick(); iDone = '0;
        tick();
        n_cmp++; if (bus.oValid !== 1'b1 || bus.oData !== 12'h3C3 || bus.oCh !== 2'd1) begin n_bad++; $display("FAIL rm_resume: valid=%b data=%h ch=%0d want 1 3c3 1", bus.oValid, bus.oData, bus.oCh); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                iDone[i] = ($urandom_range(0, 3) == 0);
                set_tdc(i, W'($urandom));
            end
            bus.iReady = (c % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            iEnable    = ($urandom_range(0, 9) != 0);
            iClrOvf    = ($urandom_range(0, 19) == 0);
            tick();
            n_cmp++;
            if (bus.oValid !== m_valid || oArm !== m_arm || oOvf !== m_ovf ||
                (m_valid && (bus.oData !== m_out || int'(bus.oCh) != m_ch))) begin
                n_bad++;
                $display("FAIL rand_c%0d: valid=%b data=%h ch=%0d arm=%h ovf=%h want %b %h %0d %h %h",
                         c, bus.oValid, bus.oData, bus.oCh, oArm, oOvf, m_valid, m_out, m_ch, m_arm, m_ovf);
            end
        end
        iDone = '0; iClrOvf = 1'b0; iEnable = 1'b1; bus.iReady = 1'b1;
        for (int c = 0; c < 12; c++) tick();
        n_cmp++; if (bus.oValid !== 1'b0 || oArm !== 4'hF) begin n_bad++; $display("FAIL rand_drain: valid=%b arm=%h want 0 f", bus.oValid, oArm); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_same_cycle();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
